// File: rtl/key_sw_input_port_pkg.sv
// ---------------------------------------------------------------------------
// key_sw_input_port_pkg
//   Shared constants for the KEY/SW input peripheral: the CPU-visible register
//   addresses and the default debounce interval.
// ---------------------------------------------------------------------------
package key_sw_input_port_pkg;

    // 10 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Read register map seen by the CPU core.
    typedef enum logic [1:0] {
        ADDR_SW_LO   = 2'd0,  // debounced SW[7:0]
        ADDR_SW_HI   = 2'd1,  // debounced SW[9:8]
        ADDR_KEY_LVL = 2'd2,  // debounced key levels, pressed = 1
        ADDR_KEY_EVT = 2'd3   // sticky press flags, cleared by this read
    } rd_addr_e;

endpackage

// File: rtl/key_sw_input_port_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   Brings one asynchronous board input into the clk domain through a
//   2-flop synchronizer, then accepts a level change only after the
//   synchronized value has disagreed with the current level for
//   DEBOUNCE_CYCLES consecutive cycles.
//
//   The level is kept in the polarity of the raw pin; RESET_LEVEL is the
//   idle value of the pin and is loaded into both synchronizer flops and the
//   debounced level on reset. DEBOUNCE_CYCLES must be at least 1.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   raw    in   asynchronous board input
//   level  out  debounced level, same polarity as raw
// ---------------------------------------------------------------------------
module debounce_bit
    import key_sw_input_port_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments make sync_q2 take the value sync_q1 held
    // before this edge, so the chain really is two flops deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= RESET_LEVEL;
            sync_q2 <= RESET_LEVEL;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // The level flips on the same edge that would have made the count reach
    // DEBOUNCE_CYCLES, so a steady change appears 2 + DEBOUNCE_CYCLES edges
    // after it is first sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= RESET_LEVEL;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_q2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_sw_input_port.sv
// ---------------------------------------------------------------------------
// key_sw_input_port
//   Read-side board peripheral for the PIC10-compatible CPU. Debounces the
//   four push-buttons and ten slide switches, latches key-press events into
//   sticky flags, and exposes everything as four byte-wide read registers.
//   A debounced press of KEY[1] also produces a one-cycle step_pulse for
//   clock-enable single stepping.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   KEY[3:0]    in   raw push-buttons, active-low, asynchronous
//   SW[9:0]     in   raw slide switches, active-high, asynchronous
//   rd_en       in   CPU read strobe
//   rd_addr     in   register select (see rd_addr_e)
//   rd_data     out  registered read data, holds while rd_en = 0
//   step_pulse  out  one-cycle pulse per debounced KEY[1] press
// ---------------------------------------------------------------------------
module key_sw_input_port
    import key_sw_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_KEYS        = 4,   // register map assumes 4
    parameter int NUM_SW          = 10   // register map assumes 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    input  logic                rd_en,
    input  logic [1:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic                step_pulse
);

    localparam int STEP_KEY = 1;

    rd_addr_e            rd_sel;
    logic [NUM_SW-1:0]   sw_lvl;       // debounced switches
    logic [NUM_KEYS-1:0] key_pin_lvl;  // debounced keys, pin polarity (pressed = 0)
    logic [NUM_KEYS-1:0] key_lvl;      // debounced keys, pressed = 1
    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] flag_clr;
    logic [NUM_KEYS-1:0] press_flags;
    logic [7:0]          rd_next;

    // -----------------------------------------------------------------------
    // Per-bit synchronize + debounce
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b0)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (SW[i]),
            .level (sw_lvl[i])
        );
    end

    // Keys are debounced in pin polarity (idle = 1) and inverted afterwards;
    // inverting a debounced level is identical to debouncing the inverted
    // input, and it lets the synchronizer reset to the released pin value.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (KEY[i]),
            .level (key_pin_lvl[i])
        );
    end

    assign key_lvl = ~key_pin_lvl;

    // -----------------------------------------------------------------------
    // Press detection and sticky flags
    // -----------------------------------------------------------------------
    assign rd_sel    = rd_addr_e'(rd_addr);
    assign key_press = key_lvl & ~key_prev;
    assign flag_clr  = (rd_en && (rd_sel == ADDR_KEY_EVT)) ? '1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev    <= '0;
            press_flags <= '0;
            step_pulse  <= 1'b0;
        end else begin
            key_prev    <= key_lvl;
            // Set has priority: a press landing on a clearing read survives.
            press_flags <= (press_flags & ~flag_clr) | key_press;
            step_pulse  <= key_press[STEP_KEY];
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and registered read port
    // -----------------------------------------------------------------------
    // NOTE: default assignment before the case keeps this purely
    // combinational for every rd_sel value.
    always_comb begin
        rd_next = 8'h00;
        case (rd_sel)
            ADDR_SW_LO:   rd_next = sw_lvl[7:0];
            ADDR_SW_HI:   rd_next = 8'(sw_lvl[NUM_SW-1:8]);
            ADDR_KEY_LVL: rd_next = 8'(key_lvl);
            ADDR_KEY_EVT: rd_next = 8'(press_flags);
            default:      rd_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_key_sw_input_port.sv
// ---------------------------------------------------------------------------
// tb_key_sw_input_port
//   Directed scenarios followed by random KEY/SW/read traffic. A reference
//   model keeps the history of sampled inputs and applies the debounce rule
//   directly ("the last DEBOUNCE_CYCLES synchronized samples all disagree
//   with the level"); reads push their expected byte into a queue that a
//   negedge monitor drains against rd_data.
// ---------------------------------------------------------------------------
module tb_key_sw_input_port;

    localparam int D = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] KEY     = 4'hF;
    logic [9:0] SW      = 10'h000;
    logic       rd_en   = 1'b0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       step_pulse;

    always #5 clk = ~clk;

    key_sw_input_port #(
        .DEBOUNCE_CYCLES (D),
        .NUM_KEYS        (4),
        .NUM_SW          (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .KEY        (KEY),
        .SW         (SW),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .step_pulse (step_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model (updated on every rising edge)
    //   bits 9:0 = switches, bits 13:10 = keys with pressed = 1
    // -----------------------------------------------------------------------
    logic [13:0] hist[$];      // sampled inputs, newest last
    logic [13:0] deb_m   = '0;
    logic [3:0]  rose_m  = '0; // keys whose level rose on the latest edge
    logic [3:0]  flags_m = '0;
    logic        step_m  = 1'b0;
    logic        rd_fire = 1'b0;
    logic        in_reset_m = 1'b1;
    logic        model_live = 1'b0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) begin : model
        logic [13:0] raw_now;
        logic [13:0] next_deb;
        logic [7:0]  e;
        logic        all_diff;
        raw_now    = {~KEY, SW};
        model_live = 1'b1;
        in_reset_m = rst;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < D + 1; k++) hist.push_back('0);
            deb_m   = '0;
            rose_m  = '0;
            flags_m = '0;
            step_m  = 1'b0;
            rd_fire = 1'b0;
        end else begin
            rd_fire = rd_en;
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    e = deb_m[7:0];
                    2'd1:    e = {6'b0, deb_m[9:8]};
                    2'd2:    e = {4'b0, deb_m[13:10]};
                    default: e = {4'b0, flags_m};
                endcase
                exp_q.push_back(e);
            end
            // Events from the previous edge become visible now.
            step_m  = rose_m[1];
            flags_m = ((rd_en && rd_addr == 2'd3) ? 4'h0 : flags_m) | rose_m;
            // A synchronized sample is the input taken two edges earlier.
            next_deb = deb_m;
            for (int i = 0; i < 14; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[hist.size() - 2 - j][i] == deb_m[i]) all_diff = 1'b0;
                if (all_diff) next_deb[i] = ~deb_m[i];
            end
            rose_m = next_deb[13:10] & ~deb_m[13:10];
            deb_m  = next_deb;
            hist.push_back(raw_now);
            if (hist.size() > D + 2) void'(hist.pop_front());
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: compares outputs away from the rising edge
    // -----------------------------------------------------------------------
    logic [7:0] hold_val = 8'h00;

    always @(negedge clk) begin : monitor
        if (model_live) begin
            if (in_reset_m) begin
                hold_val = 8'h00;
                check("rd_data_reset", rd_data, hold_val);
            end else if (rd_fire) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_queue: read seen with no expectation, got %h", rd_data);
                end else begin
                    hold_val = exp_q.pop_front();
                    check("rd_data", rd_data, hold_val);
                end
            end else begin
                check("rd_hold", rd_data, hold_val);
            end
            check("step_pulse", {7'b0, step_pulse}, {7'b0, step_m});
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after a rising edge)
    // -----------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_expect(input logic [1:0] a, input logic [7:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        tick(1);
        rd_en   = 1'b0;
        check(name, rd_data, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset with keys released and switches low.
        rst = 1'b1;
        KEY = 4'hF;
        SW  = 10'h000;
        tick(3);
        rst = 1'b0;
        rd_expect(2'd0, 8'h00, "reset_addr0");
        rd_expect(2'd1, 8'h00, "reset_addr1");
        rd_expect(2'd2, 8'h00, "reset_addr2");
        rd_expect(2'd3, 8'h00, "reset_addr3");

        // Switch debounce and glitch rejection.
        SW = 10'h2A5;
        tick(6);
        rd_expect(2'd0, 8'hA5, "sw_lo");
        rd_expect(2'd1, 8'h02, "sw_hi");
        SW = 10'h2A4;
        tick(3);
        SW = 10'h2A5;
        tick(10);
        rd_expect(2'd0, 8'hA5, "sw_glitch");

        // KEY[1] press: pulse 7 edges after the drive, flag read and cleared.
        KEY = 4'hD;
        tick(6);
        check("step_before", {7'b0, step_pulse}, 8'h00);
        tick(1);
        check("step_on", {7'b0, step_pulse}, 8'h01);
        tick(1);
        check("step_off", {7'b0, step_pulse}, 8'h00);
        rd_expect(2'd3, 8'h02, "flags_key1");
        rd_expect(2'd3, 8'h00, "flags_cleared");
        rd_expect(2'd2, 8'h02, "level_key1");
        KEY = 4'hF;
        tick(8);
        rd_expect(2'd2, 8'h00, "level_released");

        // Bounce on KEY[2]: toggles every 2 cycles, ends released.
        for (int t = 0; t < 10; t++) begin
            KEY[2] = ~KEY[2];
            tick(2);
        end
        tick(10);
        rd_expect(2'd3, 8'h00, "bounce_flags");
        rd_expect(2'd2, 8'h00, "bounce_level");

        // KEY[0] press event coincides with a clearing read.
        KEY = 4'hE;
        tick(6);
        rd_expect(2'd3, 8'h00, "set_wins_old");
        rd_expect(2'd3, 8'h01, "set_wins_new");
        KEY = 4'hF;
        tick(8);

        // Reset while KEY[3] is held: it registers again as a fresh press.
        KEY = 4'h7;
        tick(6);
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rd_expect(2'd3, 8'h00, "flags_after_reset");
        tick(6);
        rd_expect(2'd3, 8'h08, "fresh_press_after_reset");
        KEY = 4'hF;
        tick(8);

        // Random traffic checked by the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) SW[$urandom_range(0, 9)] = ~SW[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) KEY[$urandom_range(0, 3)] = ~KEY[$urandom_range(0, 3)];
            if ($urandom_range(0, 2) == 0) begin
                rd_en   = 1'b1;
                rd_addr = 2'($urandom_range(0, 3));
            end else begin
                rd_en = 1'b0;
            end
            tick(1);
        end
        rd_en = 1'b0;
        KEY   = 4'hF;
        tick(10);
        rd_expect(2'd2, 8'h00, "final_keys_released");
        tick(2);

        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
